imem_loader: RTL

//  Boot-time program loader. Write-side counterpart of the fetch path: receives a

---
 rtl/imem_loader_if.sv | 19 +
 rtl/imem_loader.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/imem_loader_if.sv
// Loader bus bundle: RX byte handshake in, instruction BRAM port-A write signals out.
interface imem_loader_if;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        rx_ready;
   logic [3:0]  mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;

   modport master (
      input  rx_valid, rx_data,
      output rx_ready, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      output rx_valid, rx_data,
      input  rx_ready, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: assembles a little-endian byte stream into words, writes them to IMEM port A and
// holds the CPU in reset until the image is in. IMEM_LOADER_CHECKSUM_EN adds a trailing checksum.
module imem_loader #(
   parameter int unsigned MAX_WORDS = 4096,
   parameter logic [31:0] BASE_ADDR = 32'h0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   imem_loader_if.master bus,
   output logic          cpu_rst_n,
   output logic          busy,
   output logic          done,
   output logic          err
);
   localparam int unsigned IW = $clog2(MAX_WORDS + 1);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_LEN  = 3'd1;
   localparam logic [2:0] S_DATA = 3'd2;
`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam logic [2:0] S_CHK  = 3'd3;
`endif
   localparam logic [2:0] S_DONE = 3'd4;
   localparam logic [2:0] S_ERR  = 3'd5;

   logic [2:0]    state_q, state_d;
   logic [1:0]    byte_q, byte_d;
   logic [IW-1:0] word_q, word_d, len_q, len_d, word_inc;
   logic [23:0]   asm_q, asm_d, asm_ins;
   logic          fin_q, fin_d, we_q, we_d;
   logic [31:0]   addr_q, addr_d, wdata_q, wdata_d, word_full;
   logic          accept, last_byte;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [31:0]   sum_q, sum_d;
`endif

   assign accept    = bus.rx_valid && bus.rx_ready;
   assign last_byte = (byte_q == 2'd3);
   assign word_full = {bus.rx_data, asm_q};
   assign word_inc  = word_q + IW'(1);

   // Only the low three bytes are buffered; the fourth arrives with the completing beat.
   always_comb begin
      asm_ins = asm_q;
      case (byte_q)
         2'd0:    asm_ins[7:0]   = bus.rx_data;
         2'd1:    asm_ins[15:8]  = bus.rx_data;
         2'd2:    asm_ins[23:16] = bus.rx_data;
         default: asm_ins = asm_q;
      endcase
   end

   always_comb begin
      state_d = state_q;
      byte_d  = byte_q;
      word_d  = word_q;
      len_d   = len_q;
      asm_d   = asm_q;
      fin_d   = fin_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_d   = sum_q;
`endif
      case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
               state_d = S_LEN;
               byte_d  = 2'd0;
               word_d  = '0;
               asm_d   = '0;
               fin_d   = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
               sum_d   = '0;
`endif
            end
         end
         S_LEN: begin
            if (accept) begin
               asm_d  = asm_ins;
               byte_d = byte_q + 2'd1;
               if (last_byte) begin
                  len_d = word_full[IW-1:0];
                  if (word_full == 32'd0 || word_full > MAX_WORDS) state_d = S_ERR;
                  else                                              state_d = S_DATA;
               end
            end
         end
         S_DATA: begin
            // fin_q marks the write cycle of the last word; leave only once it has landed.
            if (fin_q) begin
               fin_d = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
               state_d = S_CHK;
`else
               state_d = S_DONE;
`endif
            end else if (accept) begin
               asm_d  = asm_ins;
               byte_d = byte_q + 2'd1;
               if (last_byte) begin
                  we_d    = 1'b1;
                  addr_d  = BASE_ADDR + 32'({word_q, 2'b00});
                  wdata_d = word_full;
                  word_d  = word_inc;
                  fin_d   = (word_inc == len_q);
`ifdef IMEM_LOADER_CHECKSUM_EN
                  sum_d   = sum_q + word_full;
`endif
               end
            end
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         S_CHK: begin
            if (accept) begin
               asm_d  = asm_ins;
               byte_d = byte_q + 2'd1;
               if (last_byte) state_d = (word_full == sum_q) ? S_DONE : S_ERR;
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         byte_q  <= 2'd0;
         word_q  <= '0;
         len_q   <= '0;
         asm_q   <= '0;
         fin_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= BASE_ADDR;
         wdata_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         sum_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         byte_q  <= byte_d;
         word_q  <= word_d;
         len_q   <= len_d;
         asm_q   <= asm_d;
         fin_q   <= fin_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
         sum_q   <= sum_d;
`endif
      end
   end

`ifdef IMEM_LOADER_CHECKSUM_EN
   assign busy = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CHK);
`else
   assign busy = (state_q == S_LEN) || (state_q == S_DATA);
`endif
   assign bus.rx_ready  = busy && !fin_q;
   assign bus.mem_we    = {4{we_q}};
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign done          = (state_q == S_DONE);
   assign err           = (state_q == S_ERR);
   assign cpu_rst_n     = (state_q == S_DONE);
endmodule
